// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide_add_seq sequencer: FSM encodings, word width and
// the word-index counter width helper.
package wide_add_seq_pkg;

   localparam int unsigned WordW = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Word index width; a single-word operand still needs a 1-bit counter.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Requester-side handshake and operand bus of wide_add_seq.
// Optional macro WIDE_ADD_SUB_EN adds the subtract-select signal `sub`.
interface wide_add_seq_if #(
   parameter int unsigned WORDS = 4
);
   import wide_add_seq_pkg::*;

   localparam int unsigned W = WORDS * WordW;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef WIDE_ADD_SUB_EN
   logic         sub;
`endif
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output start, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
      output sub,
`endif
      input  ready, busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
      input  sub,
`endif
      output ready, busy, done, sum, cout
   );

endinterface

// File: rtl/wide_add_seq_fulladder16.sv
// 16-bit ripple-carry adder slice shared across all words of the wide operation.
module wide_add_seq_fulladder16
   import wide_add_seq_pkg::*;
(
   input  logic [WordW-1:0] a_i,
   input  logic [WordW-1:0] b_i,
   input  logic             ci_i,
   output logic [WordW-1:0] s_o,
   output logic             co_o
);

   logic [WordW:0] c;

   assign c[0] = ci_i;

   for (genvar i = 0; i < WordW; i++) begin : g_bit
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign co_o = c[WordW];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle (16*WORDS)-bit adder: one 16-bit slice is reused for WORDS cycles,
// carry held in a register between passes.
// Optional macro WIDE_ADD_SUB_EN enables A-B via inverted B and forced carry-in.
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic           clk,
   input  logic           rst,
   wide_add_seq_if.slave  bus
);

   localparam int unsigned W    = WORDS * WordW;
   localparam int unsigned IdxW = idx_width(WORDS);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS - 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

   logic [WordW-1:0] a_word, b_word, s_word;
   logic             co_word;

   // Word-select muxes feeding the shared adder slice.
   assign a_word = a_q[WordW*idx_q +: WordW];
   assign b_word = b_q[WordW*idx_q +: WordW];

   wide_add_seq_fulladder16 u_fulladder16 (
      .a_i  (a_word),
      .b_i  (b_word),
      .ci_i (carry_q),
      .s_o  (s_word),
      .co_o (co_word)
   );

   // Next-state: accept starts outside RUN, step one word per RUN cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StRun;
               idx_d   = '0;
               a_d     = bus.a;
`ifdef WIDE_ADD_SUB_EN
               // Two's-complement subtract: invert B now, inject +1 as carry-in.
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
`else
               b_d     = bus.b;
               carry_d = bus.cin;
`endif
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            sum_d[WordW*idx_q +: WordW] = s_word;
            carry_d = co_word;
            if (idx_q == IdxLast) begin
               state_d = StDone;
               cout_d  = co_word;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.ready = (state_q != StRun);
   assign bus.busy  = (state_q == StRun);
   assign bus.done  = (state_q == StDone);
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (WORDS=4 and WORDS=1 instances).
module tb_wide_add_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   wide_add_seq_if #(.WORDS(4)) bus4 ();
   wide_add_seq_if #(.WORDS(1)) bus1 ();

   wide_add_seq #(.WORDS(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   wide_add_seq #(.WORDS(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a start for one cycle; returns at the negedge of cycle k+1.
   task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub);
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.a     = a;
      bus4.b     = b;
      bus4.cin   = cin;
`ifdef WIDE_ADD_SUB_EN
      bus4.sub   = sub;
`else
      if (sub) $display("note: sub ignored in add-only build");
`endif
      @(posedge clk);
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   // Four RUN cycles k+1..k+4; returns at the negedge of cycle k+5.
   task automatic expect_run4(input string tag);
      for (int i = 0; i < 4; i++) begin
         check_eq({tag, "_busy"}, 64'(bus4.busy), 64'd1);
         check_eq({tag, "_done_in_run"}, 64'(bus4.done), 64'd0);
         check_eq({tag, "_ready_in_run"}, 64'(bus4.ready), 64'd0);
         @(negedge clk);
      end
   endtask

   task automatic expect_done4(input string tag, input logic [63:0] sum, input logic cout);
      check_eq({tag, "_done"}, 64'(bus4.done), 64'd1);
      check_eq({tag, "_busy_off"}, 64'(bus4.busy), 64'd0);
      check_eq({tag, "_ready"}, 64'(bus4.ready), 64'd1);
      check_eq({tag, "_sum"}, bus4.sum, sum);
      check_eq({tag, "_cout"}, 64'(bus4.cout), 64'(cout));
   endtask

   task automatic expect_reset_outputs(input string tag);
      check_eq({tag, "_sum4"}, bus4.sum, 64'd0);
      check_eq({tag, "_cout4"}, 64'(bus4.cout), 64'd0);
      check_eq({tag, "_done4"}, 64'(bus4.done), 64'd0);
      check_eq({tag, "_busy4"}, 64'(bus4.busy), 64'd0);
      check_eq({tag, "_ready4"}, 64'(bus4.ready), 64'd1);
   endtask

   initial begin
      bus4.start = 1'b0;
      bus4.a     = '0;
      bus4.b     = '0;
      bus4.cin   = 1'b0;
      bus1.start = 1'b0;
      bus1.a     = '0;
      bus1.b     = '0;
      bus1.cin   = 1'b0;
`ifdef WIDE_ADD_SUB_EN
      bus4.sub   = 1'b0;
      bus1.sub   = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      expect_reset_outputs("reset");
      check_eq("reset_sum1", 64'(bus1.sum), 64'd0);
      check_eq("reset_ready1", 64'(bus1.ready), 64'd1);
      rst = 1'b0;

      // Carry out of word 0 into word 1.
      start4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
      expect_run4("t1");
      expect_done4("t1", 64'h0000_0000_0001_0000, 1'b0);
      @(negedge clk);
      check_eq("t1_done_pulse", 64'(bus4.done), 64'd0);
      check_eq("t1_sum_hold", bus4.sum, 64'h0000_0000_0001_0000);

      // Carry ripples through all four passes.
      start4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
      expect_run4("t2");
      expect_done4("t2", 64'd0, 1'b1);

      // Ignored start during RUN, then back-to-back start in the DONE cycle.
      start4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
      @(negedge clk);                       // cycle k+2
      bus4.start = 1'b1;
      bus4.a     = 64'd0;
      bus4.b     = 64'd0;
      bus4.cin   = 1'b1;
      @(negedge clk);                       // cycle k+3
      bus4.start = 1'b0;
      check_eq("t3_busy_k3", 64'(bus4.busy), 64'd1);
      @(negedge clk);                       // cycle k+4
      check_eq("t3_busy_k4", 64'(bus4.busy), 64'd1);
      @(negedge clk);                       // cycle k+5
      expect_done4("t3a", 64'h2345_6789_ABCD_F001, 1'b0);
      bus4.start = 1'b1;
      bus4.a     = 64'h8000_0000_0000_0000;
      bus4.b     = 64'h8000_0000_0000_0000;
      bus4.cin   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.start = 1'b0;
      expect_run4("t3b");
      expect_done4("t3b", 64'd1, 1'b1);

      // Reset mid-run aborts with no done pulse.
      start4(64'd1, 64'd1, 1'b0, 1'b0);
      @(negedge clk);                       // cycle k+2
      rst = 1'b1;
      @(negedge clk);
      expect_reset_outputs("t4_rst");
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("t4_no_done", 64'(bus4.done), 64'd0);
      end
      start4(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
      expect_run4("t4");
      expect_done4("t4", 64'h0000_0001_0000_0000, 1'b1);

`ifdef WIDE_ADD_SUB_EN
      // Subtraction with borrow, Cin ignored.
      start4(64'd5, 64'd7, 1'b0, 1'b1);
      expect_run4("t6a");
      expect_done4("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      start4(64'd7, 64'd5, 1'b0, 1'b1);
      expect_run4("t6b");
      expect_done4("t6b", 64'd2, 1'b1);
      bus4.sub = 1'b0;
`endif

      // Single-word instance: one RUN cycle, done at k+2.
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.a     = 16'hFFFF;
      bus1.b     = 16'h0001;
      bus1.cin   = 1'b0;
      @(posedge clk);
      @(negedge clk);                       // cycle k+1
      bus1.start = 1'b0;
      check_eq("t5_busy", 64'(bus1.busy), 64'd1);
      check_eq("t5_done_early", 64'(bus1.done), 64'd0);
      @(negedge clk);                       // cycle k+2
      check_eq("t5_done", 64'(bus1.done), 64'd1);
      check_eq("t5_busy_off", 64'(bus1.busy), 64'd0);
      check_eq("t5_sum", 64'(bus1.sum), 64'd0);
      check_eq("t5_cout", 64'(bus1.cout), 64'd1);
      @(negedge clk);
      check_eq("t5_done_pulse", 64'(bus1.done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle sequencer that performs a (16·WORDS)-bit addition by time-sharing one 16-bit ripple adder slice, `fulladder16`, across WORDS consecutive cycles. The carry is held in a register between passes. The block sits between a requester with a start/done handshake and the adder datapath. It trades latency for area when operand width exceeds 16 bits.

## Interface
- `WORDS`, default 4: number of 16-bit words per operand. Legal range 1..16. Operand width is W = 16·WORDS.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an operation. Sampled only when `ready`=1.
- `A` in W: operand A. Latched on an accepted start.
- `B` in W: operand B. Latched on an accepted start.
- `Cin` in 1: carry into word 0. Latched on an accepted start.
- `Sub` in 1: subtract select. Present only with `WIDE_ADD_SUB_EN`.
- `ready` out 1: high when a start can be accepted (state ≠ RUN).
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse marking a completed result.
- `Sum` out W: result register.
- `Cout` out 1: carry out of the most significant word.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`.
- RUN → RUN while word index `idx` < WORDS-1.
- RUN → DONE when `idx` = WORDS-1.
- DONE → RUN on `start`. DONE → IDLE otherwise.
- Accepted start:
  - latch A and B into operand registers;
  - load the carry register with `Cin`;
  - set `idx`=0.
- Each RUN cycle:
  - the adder adds `A_r[idx]`, `B_r[idx]` and the carry register;
  - its sum is written to `Sum[16·idx +: 16]`;
  - its carry-out is written to the carry register;
  - `idx` increments.
- Entering DONE copies the carry register to `Cout`.
- `start` is ignored in RUN. There is no queuing and no error flag.
- Words of `Sum` update progressively during RUN. `Sum` is valid from the `done` cycle and holds until the next accepted start's first RUN write. `Cout` holds until the next DONE.
- Wrap-around: the sum is modulo 2^W. The overflow is visible only in `Cout`.
- Reset values:
  - state IDLE, `idx`=0, carry=0;
  - `Sum`=0, `Cout`=0, `done`=0, `busy`=0, `ready`=1.
- Reset mid-RUN aborts the operation. No `done` is issued for it.
- Reset takes priority over a simultaneous `start`.

## Timing
- Latency: if `start` is sampled at edge k, RUN covers cycles k+1..k+WORDS and `done`=1 in cycle k+WORDS+1.
- `busy`=1 exactly WORDS cycles per operation.
- Back-to-back operation: `start` asserted during DONE is accepted. `done` still pulses that cycle. Throughput is one operation per WORDS+1 cycles.
- WORDS=1 case: exactly one RUN cycle, and `done` at k+2.
- The adder path is combinational within one cycle. Critical path: operand mux → 16-bit ripple → Sum/carry registers.

## Configuration
- `WIDE_ADD_SUB_EN` defined:
  - the `Sub` port exists and is latched on start;
  - with `Sub`=1, B is bitwise inverted at latch time and the carry register is loaded with 1 (`Cin` ignored);
  - the result is A−B modulo 2^W;
  - `Cout`=1 means no borrow (A ≥ B unsigned).
- `WIDE_ADD_SUB_EN` undefined: no `Sub` port, add only, identical timing.

## Structure
- Shared package/header: FSM state encodings (IDLE, RUN, DONE) and the word width constant 16.
- One sub-module: a single `fulladder16` instance, fed by word-select muxes on `A_r`/`B_r` indexed by `idx`.
- The counter width is derived from WORDS.

## Test plan
- Single-word carry: WORDS=4, A=0x0000_0000_0000_FFFF, B=1, Cin=0, start at edge k.
  - `busy` high k+1..k+4;
  - `done` at k+5;
  - `Sum`=0x0000_0000_0001_0000, `Cout`=0.
- Full carry ripple: WORDS=4, A=all ones, B=0, Cin=1 → `Sum`=0, `Cout`=1. This proves the carry propagates across all four passes.
- Busy and back-to-back:
  - `start` with new operands at k+2 is ignored, and the first result is correct;
  - a `start` pulsed in the DONE cycle yields a second `done` exactly 5 cycles later.
- Reset mid-run: `rst` at k+2.
  - all outputs return to reset values the next cycle;
  - no `done` pulse appears;
  - a subsequent operation is correct.
- WORDS=1: A=0xFFFF, B=0x0001 → `done` at k+2, `Sum`=0x0000, `Cout`=1.
- `WIDE_ADD_SUB_EN`, WORDS=4:
  - A=5, B=7, `Sub`=1 → `Sum`=0xFFFF_FFFF_FFFF_FFFE, `Cout`=0;
  - A=7, B=5 → `Sum`=2, `Cout`=1.
